// File: rtl/ysyx_22041211_mem_arbiter.sv
// ysyx_22041211_mem_arbiter: shares one memory port between IFU and LSU, LSU priority with an IFU starvation guard
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN     = 32,
    parameter int DATA_LEN     = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_addr,
    output logic                ifu_rvalid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [3:0]          lsu_wmask,
    output logic                lsu_rvalid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [3:0]          mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                protocol_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    state_e                state_q;
    logic [3:0]            streak_q, streak_d;
    logic                  owner_lsu_q;
    logic [ADDR_LEN-1:0]   addr_q;
    logic                  wen_q;
    logic [DATA_LEN-1:0]   wdata_q, ifu_rdata_q, lsu_rdata_q;
    logic [3:0]            wmask_q;
    logic                  ifu_rvalid_q, lsu_rvalid_q, err_q;
    logic                  grant_lsu, grant_ifu;
    // Ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        grant_lsu = ~rst && state_q == IDLE && lsu_req_valid && !(ifu_req_valid && streak_q == LIM);
        grant_ifu = ~rst && state_q == IDLE && ifu_req_valid && !grant_lsu;
        streak_d  = (grant_lsu && ifu_req_valid) ? ((streak_q == LIM) ? LIM : streak_q + 4'd1) : 4'd0;
    end
    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign mem_req_valid = state_q == REQ;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rvalid    = ifu_rvalid_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rvalid    = lsu_rvalid_q;
    assign lsu_rdata     = lsu_rdata_q;
    assign protocol_err  = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            owner_lsu_q  <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_rvalid) err_q <= 1'b1;
                    if (grant_lsu || grant_ifu) begin
                        owner_lsu_q <= grant_lsu;
                        addr_q      <= grant_lsu ? lsu_addr : ifu_addr;
                        wen_q       <= grant_lsu && lsu_wen;
                        wdata_q     <= grant_lsu ? lsu_wdata : '0;
                        wmask_q     <= grant_lsu ? lsu_wmask : 4'hf;
                        streak_q    <= streak_d;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rvalid) err_q <= 1'b1;
                    if (mem_req_ready) state_q <= RESP;
                end
                RESP: begin
                    if (mem_rvalid) begin
                        if (owner_lsu_q) begin
                            lsu_rdata_q  <= mem_rdata;
                            lsu_rvalid_q <= 1'b1;
                        end else begin
                            ifu_rdata_q  <= mem_rdata;
                            ifu_rvalid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_22041211_mem_arbiter.md
Name: ysyx_22041211_mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU). One transaction is outstanding at a time.
- Uses valid/ready handshakes upstream and a request/response handshake downstream.
- Priority: LSU wins ties, with a starvation guard that forces an IFU grant after a run of contested LSU grants.
- Sits between the IFU/LSU and the pmem bridge, replacing direct DPI memory calls from the datapath.

Parameters:
ADDR_LEN, 32, address width
DATA_LEN, 32, data width
STARVE_LIMIT, 4, consecutive contested LSU grants before IFU is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_LEN  fetch address
ifu_rvalid  out  1  one-cycle pulse: fetch data valid
ifu_rdata  out  DATA_LEN  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_LEN  load/store address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_LEN  store data
lsu_wmask  in  4  byte strobes
lsu_rvalid  out  1  one-cycle pulse: load data / store ack
lsu_rdata  out  DATA_LEN  load data
mem_req_valid  out  1  downstream request
mem_req_ready  in  1  downstream accepted request
mem_addr  out  ADDR_LEN  latched address
mem_wen  out  1  latched write enable (0 for IFU)
mem_wdata  out  DATA_LEN  latched store data (0 for IFU)
mem_wmask  out  4  latched strobes (4'b1111 for IFU reads)
mem_rvalid  in  1  downstream response
mem_rdata  in  DATA_LEN  downstream read data
protocol_err  out  1  sticky flag: unexpected mem_rvalid

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; streak counter = 0; latched request fields = 0.
  - All outputs = 0, including protocol_err.
  - An in-flight transaction is dropped; no rvalid is issued for it.
- States: IDLE, REQ, RESP.
- IDLE:
  - Grant is combinational:
    - Both valid and streak < STARVE_LIMIT → LSU.
    - Both valid and streak == STARVE_LIMIT → IFU.
    - Otherwise → whichever requester is valid.
  - The winner's req_ready = 1. The loser's req_ready = 0, and it holds its request stable.
  - On handshake: latch addr/wen/wdata/wmask and owner; go to REQ.
  - req_ready is 0 in REQ and RESP.
- Streak counter, updated on each grant:
  - LSU grant while ifu_req_valid=1 → increment, saturating at STARVE_LIMIT.
  - IFU grant, or LSU grant with IFU idle → clear to 0.
- REQ: mem_req_valid = 1 with latched fields held stable. On mem_req_ready=1 → RESP.
- RESP: mem_req_valid = 0. On mem_rvalid=1:
  - Register mem_rdata into the owner's rdata.
  - Pulse the owner's rvalid for exactly one cycle, on the next cycle.
  - Go to IDLE.
- Store ack: a store (lsu_wen=1) still waits for mem_rvalid. lsu_rvalid pulses; lsu_rdata is don't-care.
- Latency: handshake at cycle 0 → mem_req_valid at cycle 1. With mem_req_ready=1 and mem_rvalid=1 at cycle 2, the owner's rvalid is at cycle 3, and a new grant is possible in cycle 3 (IDLE). Best-case throughput is one transaction per 3 cycles.
- Outputs between pulses:
  - ifu_rdata and lsu_rdata hold their last value between pulses.
  - The non-owner's rvalid stays 0.
- Protocol error: mem_rvalid=1 in IDLE or REQ is ignored and sets protocol_err, which stays set until reset. mem_rvalid and mem_req_ready arriving in the same REQ cycle count as an error for the response.
- Upstream valid dropping while waiting in IDLE is allowed; there is no grant without valid.

Test Plan:
- Single IFU fetch: ifu_addr=0x8000_0000; mem ready at once, rdata=0x0000_0413 a cycle later → ifu_rvalid at cycle 3 with ifu_rdata=0x0000_0413, mem_wmask=4'b1111, mem_wen=0.
- Contention: both valid in the same cycle → LSU granted first (lsu_req_ready=1, ifu_req_ready=0). IFU is granted at the next IDLE once the LSU request is deasserted.
- Starvation guard, STARVE_LIMIT=4: IFU and LSU both held valid continuously → grant order LSU, LSU, LSU, LSU, IFU, LSU…; streak returns to 0 after the IFU grant.
- Store with backpressure: sw addr=0x8000_1000, wdata=0xDEAD_BEEF, wmask=4'b1111; mem_req_ready held low 5 cycles → fields stable throughout, one lsu_rvalid pulse after mem_rvalid.
- Reset mid-operation: assert rst in RESP → outputs 0 immediately (async), no rvalid pulse; after release a new IFU request completes normally.
- Spurious response: mem_rvalid=1 in IDLE → protocol_err=1 and stays set, no rvalid pulse, state stays IDLE.
